// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// The fetch unit is the master and the memory is the slave.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// A one-entry skid buffer absorbs a fetch that completes while downstream is stalled.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  fetch_unit_if.master           imem,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus1,
  output logic                   if_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, SKID_FULL} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   req_q;
  logic                   drop;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // NOTE: all state lives in one clocked block using non-blocking assignments, so every
  // branch below reads pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      addr_q      <= '0;
      req_q       <= 1'b0;
      drop        <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= '0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
      if_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          addr_q <= pc;
        end

        FETCH: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if (imem.imem_ack) begin
              drop   <= 1'b0;
              addr_q <= redirect_pc;
            end else begin
              // The outstanding request must finish at its original address; its data is thrown away.
              drop <= 1'b1;
            end
          end else if (imem.imem_ack) begin
            if (drop) begin
              drop   <= 1'b0;
              addr_q <= pc;
              if (!stall) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
              end
            end else if (!if_valid || !stall) begin
              if_instr    <= imem.imem_rdata;
              if_pc       <= addr_q;
              if_pc_plus1 <= addr_q + ONE;
              if_valid    <= 1'b1;
              pc          <= addr_q + ONE;
              addr_q      <= addr_q + ONE;
            end else begin
              skid_instr <= imem.imem_rdata;
              skid_pc    <= addr_q;
              pc         <= addr_q + ONE;
              req_q      <= 1'b0;
              state      <= SKID_FULL;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
          end
        end

        SKID_FULL: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            addr_q   <= redirect_pc;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            req_q    <= 1'b1;
            state    <= FETCH;
          end else if (!stall) begin
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus1 <= skid_pc + ONE;
            if_valid    <= 1'b1;
            addr_q      <= pc;
            req_q       <= 1'b1;
            state       <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
